nios2vga_multi_timer: RTL

Parametrised multi-channel interval timer for the Nios II system bus: the successor to the single 16-bit-bus system clock timer. It provides NUM_CH independent down-counters of CNT_W bits sharing one prescaler. Each channel has one-shot/continuous modes, a write-1-to-clear timeout flag, a snapshot register and its own interrupt line; the lines are OR-reduced into one CPU irq. It sits on the Avalon-MM slave fabric beside the other peripherals.

---
 rtl/nios2vga_multi_timer_if.sv | 24 ++
 rtl/nios2vga_multi_timer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/nios2vga_multi_timer_if.sv
// Avalon-MM slave bundle for the multi-channel timer: word-addressed bus,
// registered read data and the per-channel / combined interrupt lines.
interface nios2vga_multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = $clog2(NUM_CH) + 2
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq_vec, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq_vec, irq
  );
endinterface

// File: rtl/nios2vga_multi_timer.sv
// NUM_CH independent down-counting interval timers sharing one prescaler,
// each with one-shot/continuous mode, W1C timeout flag, snapshot and irq line.
module nios2vga_multi_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE     = 1,
  parameter logic [31:0] RESET_PERIOD = 32'h30D3F,
  parameter int          ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  nios2vga_multi_timer_if.slave  bus
);

  localparam int               PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

  logic [PS_W-1:0]   r_pre;
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_ito;
  logic [NUM_CH-1:0] r_cont;
  logic [31:0]       r_readdata;

  logic              w_tick;
  logic              w_wr;
  logic [ADDR_W-1:0] w_chan;
  logic [1:0]        w_reg;
  logic [CNT_W-1:0]  w_wdata;
  logic [NUM_CH-1:0] w_stsWr;
  logic [NUM_CH-1:0] w_ctlWr;
  logic [NUM_CH-1:0] w_perWr;
  logic [NUM_CH-1:0] w_snapWr;
  logic [NUM_CH-1:0] w_expire;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_tick   = (r_pre == PS_W'(PRESCALE - 1));
  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_chan   = bus.address >> 2;
  assign w_reg    = bus.address[1:0];
  assign w_wdata  = bus.writedata[CNT_W-1:0];
  assign w_unused = ^bus.writedata;

  // A PERIOD write overrides any tick activity on the same edge, so it
  // suppresses the expiry as well as the decrement.
  always_comb begin
    w_stsWr  = '0;
    w_ctlWr  = '0;
    w_perWr  = '0;
    w_snapWr = '0;
    w_expire = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_wr && (w_chan == ADDR_W'(c))) begin
        w_stsWr[c]  = (w_reg == 2'd0);
        w_ctlWr[c]  = (w_reg == 2'd1);
        w_perWr[c]  = (w_reg == 2'd2);
        w_snapWr[c] = (w_reg == 2'd3);
      end
      w_expire[c] = w_tick && r_run[c] && (r_cnt[c] == '0) && !w_perWr[c];
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_chan == ADDR_W'(c)) begin
        case (w_reg)
          2'd0:    w_rdata = {30'd0, r_run[c], r_to[c]};
          2'd1:    w_rdata = {30'd0, r_cont[c], r_ito[c]};
          2'd2:    w_rdata = 32'(r_period[c]);
          default: w_rdata = 32'(r_snap[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre      <= '0;
      r_readdata <= '0;
      r_to       <= '0;
      r_run      <= '0;
      r_ito      <= '0;
      r_cont     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]    <= RST_P;
        r_period[c] <= RST_P;
        r_snap[c]   <= '0;
      end
    end else begin
      r_pre      <= w_tick ? '0 : r_pre + PS_W'(1);
      r_readdata <= w_rdata;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_perWr[c]) begin
          r_period[c] <= w_wdata;
          r_cnt[c]    <= w_wdata;
        end else if (w_tick && r_run[c]) begin
          r_cnt[c] <= (r_cnt[c] == '0) ? r_period[c] : r_cnt[c] - CNT_W'(1);
        end

        if (w_snapWr[c]) begin
          r_snap[c] <= r_cnt[c];
        end

        if (w_expire[c]) begin
          r_to[c] <= 1'b1;
        end else if (w_stsWr[c] && bus.writedata[0]) begin
          r_to[c] <= 1'b0;
        end

        if (w_ctlWr[c]) begin
          r_ito[c]  <= bus.writedata[0];
          r_cont[c] <= bus.writedata[1];
        end

        // STOP beats START, and START keeps a one-shot running past expiry.
        if (w_perWr[c]) begin
          r_run[c] <= 1'b0;
        end else if (w_ctlWr[c] && bus.writedata[3]) begin
          r_run[c] <= 1'b0;
        end else if (w_ctlWr[c] && bus.writedata[2]) begin
          r_run[c] <= 1'b1;
        end else if (w_expire[c] && !r_cont[c]) begin
          r_run[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq_vec  = r_to & r_ito;
  assign bus.irq      = |(r_to & r_ito);

endmodule
